// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, control-bit indices and helpers for the ID/EX stage
package mips_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    // Control bundle layout: {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, RegDst, ALUOp[3:0]}
    localparam int CTRL_W         = 10;
    localparam int CTRL_REGWRITE  = 9;
    localparam int CTRL_MEMTOREG  = 8;
    localparam int CTRL_MEMREAD   = 7;
    localparam int CTRL_MEMWRITE  = 6;
    localparam int CTRL_ALUSRC    = 5;
    localparam int CTRL_REGDST    = 4;
    localparam int CTRL_ALUOP_LSB = 0;
    localparam int CTRL_ALUOP_W   = 4;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

    // What the pipeline register does on the coming edge (reset handled separately)
    typedef enum logic [1:0] {
        EX_LOAD   = 2'd0,
        EX_HOLD   = 2'd1,
        EX_BUBBLE = 2'd2
    } ex_action_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID-side inputs and EX-side outputs of the ID/EX pipeline register
// master: upstream decode logic (drives ID_*, observes EX_*)
// slave : the ID/EX stage (reads ID_*, drives EX_*)
interface id_ex_if;
    import mips_pkg::*;

    logic [REG_W-1:0]  ID_RegisterRs;
    logic [REG_W-1:0]  ID_RegisterRt;
    logic [REG_W-1:0]  ID_RegisterRd;
    logic [DATA_W-1:0] ID_ReadData1;
    logic [DATA_W-1:0] ID_ReadData2;
    logic [DATA_W-1:0] ID_Imm;
    logic [CTRL_W-1:0] ID_Ctrl;
    logic              ID_Valid;

    logic [REG_W-1:0]  EX_RegisterRs;
    logic [REG_W-1:0]  EX_RegisterRt;
    logic [REG_W-1:0]  EX_RegisterRd;
    logic [DATA_W-1:0] EX_ReadData1;
    logic [DATA_W-1:0] EX_ReadData2;
    logic [DATA_W-1:0] EX_Imm;
    logic [CTRL_W-1:0] EX_Ctrl;
    logic              EX_Valid;

    modport master (
        output ID_RegisterRs, ID_RegisterRt, ID_RegisterRd,
        output ID_ReadData1, ID_ReadData2, ID_Imm, ID_Ctrl, ID_Valid,
        input  EX_RegisterRs, EX_RegisterRt, EX_RegisterRd,
        input  EX_ReadData1, EX_ReadData2, EX_Imm, EX_Ctrl, EX_Valid
    );

    modport slave (
        input  ID_RegisterRs, ID_RegisterRt, ID_RegisterRd,
        input  ID_ReadData1, ID_ReadData2, ID_Imm, ID_Ctrl, ID_Valid,
        output EX_RegisterRs, EX_RegisterRt, EX_RegisterRd,
        output EX_ReadData1, EX_ReadData2, EX_Imm, EX_Ctrl, EX_Valid
    );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// rtl/id_ex_stage_load_use_detect.sv - combinational load-use hazard comparator
// Inputs : decoded ID source registers/valid, EX valid/MemRead/destination Rt
// Output : o_hazard, high when ID consumes a register the EX load has not yet produced
module load_use_detect
    import mips_pkg::*;
(
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_ex_valid,
    input  logic             i_ex_memread,
    input  logic [REG_W-1:0] i_ex_rt,
    output logic             o_hazard
);

    logic w_match;

    // $zero is never really written, so a load targeting it can never be a true dependency
    assign w_match  = (i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt);
    assign o_hazard = i_id_valid & i_ex_valid & i_ex_memread & (i_ex_rt != '0) & w_match;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall, flush and memory freeze
// Ports: clk, rst (sync active-high); bus (id_ex_if.slave: ID_* in, EX_* out);
//        Flush, Mem_Busy in; PC_Write, IFID_Write out (upstream enables);
//        LoadUse_Count, Flush_Count out (saturating event counters)
module id_ex_stage
    import mips_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    id_ex_if.slave           bus,
    input  logic             Flush,
    input  logic             Mem_Busy,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic [CNT_W-1:0] LoadUse_Count,
    output logic [CNT_W-1:0] Flush_Count
);

    logic [REG_W-1:0]  r_ex_rs;
    logic [REG_W-1:0]  r_ex_rt;
    logic [REG_W-1:0]  r_ex_rd;
    logic [DATA_W-1:0] r_ex_rd1;
    logic [DATA_W-1:0] r_ex_rd2;
    logic [DATA_W-1:0] r_ex_imm;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic              r_ex_valid;
    logic [CNT_W-1:0]  r_lu_count;
    logic [CNT_W-1:0]  r_fl_count;

    logic       w_hazard;
    ex_action_e w_action;

    load_use_detect u_load_use_detect (
        .i_id_valid   (bus.ID_Valid),
        .i_id_rs      (bus.ID_RegisterRs),
        .i_id_rt      (bus.ID_RegisterRt),
        .i_ex_valid   (r_ex_valid),
        .i_ex_memread (r_ex_ctrl[CTRL_MEMREAD]),
        .i_ex_rt      (r_ex_rt),
        .o_hazard     (w_hazard)
    );

    // Flush wins over a freeze: the squashed instruction must not linger while memory stalls
    always_comb begin
        w_action = EX_LOAD;
        if (Flush)
            w_action = EX_BUBBLE;
        else if (Mem_Busy)
            w_action = EX_HOLD;
        else if (w_hazard)
            w_action = EX_BUBBLE;
    end

    // On Flush the front end must advance to the redirect target even if memory is busy
    assign PC_Write   = ~rst & (Flush | (~Mem_Busy & ~w_hazard));
    assign IFID_Write = PC_Write;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_rs    <= '0;
            r_ex_rt    <= '0;
            r_ex_rd    <= '0;
            r_ex_rd1   <= '0;
            r_ex_rd2   <= '0;
            r_ex_imm   <= '0;
            r_ex_ctrl  <= CTRL_NOP;
            r_ex_valid <= 1'b0;
            r_lu_count <= '0;
            r_fl_count <= '0;
        end else begin
            case (w_action)
                EX_BUBBLE: begin
                    r_ex_rs    <= '0;
                    r_ex_rt    <= '0;
                    r_ex_rd    <= '0;
                    r_ex_rd1   <= '0;
                    r_ex_rd2   <= '0;
                    r_ex_imm   <= '0;
                    r_ex_ctrl  <= CTRL_NOP;
                    r_ex_valid <= 1'b0;
                end
                EX_LOAD: begin
                    r_ex_rs    <= bus.ID_RegisterRs;
                    r_ex_rt    <= bus.ID_RegisterRt;
                    r_ex_rd    <= bus.ID_RegisterRd;
                    r_ex_rd1   <= bus.ID_ReadData1;
                    r_ex_rd2   <= bus.ID_ReadData2;
                    r_ex_imm   <= bus.ID_Imm;
                    r_ex_ctrl  <= bus.ID_Ctrl;
                    r_ex_valid <= bus.ID_Valid;
                end
                default: ;
            endcase

            if (Flush)
                r_fl_count <= sat_inc(r_fl_count);
            if (~Flush & ~Mem_Busy & w_hazard)
                r_lu_count <= sat_inc(r_lu_count);
        end
    end

    assign bus.EX_RegisterRs = r_ex_rs;
    assign bus.EX_RegisterRt = r_ex_rt;
    assign bus.EX_RegisterRd = r_ex_rd;
    assign bus.EX_ReadData1  = r_ex_rd1;
    assign bus.EX_ReadData2  = r_ex_rd2;
    assign bus.EX_Imm        = r_ex_imm;
    assign bus.EX_Ctrl       = r_ex_ctrl;
    assign bus.EX_Valid      = r_ex_valid;
    assign LoadUse_Count     = r_lu_count;
    assign Flush_Count       = r_fl_count;

endmodule
